// File: rtl/vend_ctrl_param.sv
// Parametrised vending-machine controller.
// Accumulates credit from 0.5/1.0/2.0 coins, dispenses one drink when the
// credit reaches PRICE, then pays change back one coin per cycle (largest
// first). Supports cancel/refund, rejects illegal or ill-timed coins and
// keeps a wrapping sales counter. All quantities are in half-unit steps.
module vend_ctrl_param #(
  parameter int PRICE = 3,
  parameter int CW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       money,
  input  logic             cancel,
  output logic             drink,
  output logic             coin_1,
  output logic             coin_0p5,
  output logic             coin_reject,
  output logic             busy,
  output logic [CW-1:0]    credit,
  output logic [CNT_W-1:0] sold_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  // Price widened to the accumulator width so the compare never truncates.
  localparam logic [CW:0] PRICE_X = (CW + 1)'(PRICE);

  state_t            state;
  logic [CW-1:0]     change;
  logic              coin_legal;
  logic              coin_any;
  logic [CW:0]       coin_val;
  logic [CW:0]       sum;

  // Value of a single legal one-hot coin; zero for no coin or multi-hot codes.
  function automatic logic [2:0] coin_units(input logic [2:0] m);
    logic [2:0] v;
    case (m)
      3'b001:  v = 3'd1;
      3'b010:  v = 3'd2;
      3'b100:  v = 3'd4;
      default: v = 3'd0;
    endcase
    return v;
  endfunction

  // Decode the sampled coin and form credit+v one bit wider than credit.
  always_comb begin
    coin_legal = 1'b0;
    coin_any   = 1'b0;
    coin_val   = '0;
    sum        = '0;
    coin_legal = (coin_units(money) != 3'd0);
    coin_any   = (money != 3'b000);
    coin_val   = (CW + 1)'(coin_units(money));
    sum        = {1'b0, credit} + coin_val;
  end

  // Controller state, credit/change bookkeeping, reject pulse and sales count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      credit      <= '0;
      change      <= '0;
      coin_reject <= 1'b0;
      sold_cnt    <= '0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (cancel && (credit != '0)) begin
            // Refund wins over any coin arriving on the same edge.
            state       <= CHANGE;
            change      <= credit;
            credit      <= '0;
            coin_reject <= coin_any;
          end else if (coin_legal) begin
            if (sum >= PRICE_X) begin
              state  <= VEND;
              change <= CW'(sum - PRICE_X);
              credit <= '0;
            end else begin
              credit <= CW'(sum);
            end
          end else begin
            // Multi-hot codes are handed straight back; no coin is a no-op.
            coin_reject <= coin_any;
          end
        end
        VEND: begin
          coin_reject <= coin_any;
          sold_cnt    <= sold_cnt + CNT_W'(1);
          if (change != '0) begin
            state <= CHANGE;
          end else begin
            state <= COLLECT;
          end
        end
        CHANGE: begin
          coin_reject <= coin_any;
          if (change >= CW'(2)) begin
            change <= change - CW'(2);
            if (change == CW'(2)) begin
              state <= COLLECT;
            end else begin
              state <= CHANGE;
            end
          end else begin
            change <= '0;
            state  <= COLLECT;
          end
        end
        default: begin
          state  <= COLLECT;
          credit <= '0;
          change <= '0;
        end
      endcase
    end
  end

  // Dispense/hopper strobes depend only on registered state and change.
  assign drink    = (state == VEND);
  assign coin_1   = (state == CHANGE) && (change >= CW'(2));
  assign coin_0p5 = (state == CHANGE) && (change == CW'(1));
  assign busy     = (state != COLLECT);

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param (PRICE=3, CW=4, CNT_W=2).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the edge just taken.
module tb_vend_ctrl_param;

  logic       clk;
  logic       rst;
  logic [2:0] money;
  logic       cancel;
  logic       drink;
  logic       coin_1;
  logic       coin_0p5;
  logic       coin_reject;
  logic       busy;
  logic [3:0] credit;
  logic [1:0] sold_cnt;

  int checks = 0;
  int errors = 0;

  vend_ctrl_param #(.PRICE(3), .CW(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .money(money), .cancel(cancel),
    .drink(drink), .coin_1(coin_1), .coin_0p5(coin_0p5),
    .coin_reject(coin_reject), .busy(busy), .credit(credit),
    .sold_cnt(sold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output at once: {drink, coin_1, coin_0p5, coin_reject, busy}.
  task automatic chk_all(input string tag, input logic [4:0] flags,
                         input logic [3:0] exp_credit, input logic [1:0] exp_sold);
    chk({tag, ".flags"}, {27'd0, drink, coin_1, coin_0p5, coin_reject, busy}, {27'd0, flags});
    chk({tag, ".credit"}, {28'd0, credit}, {28'd0, exp_credit});
    chk({tag, ".sold"}, {30'd0, sold_cnt}, {30'd0, exp_sold});
  endtask

  task automatic step(input logic [2:0] m, input logic c);
    money  = m;
    cancel = c;
    @(posedge clk);
    #1;
  endtask

  // flags order: drink coin_1 coin_0p5 coin_reject busy
  initial begin
    rst = 1'b1; money = 3'b000; cancel = 1'b0;
    step(3'b000, 1'b0);
    chk_all("reset", 5'b00000, 4'd0, 2'd0);
    rst = 1'b0;

    // Three 0.5 coins: credit 1, 2, then drink with no change.
    step(3'b001, 1'b0); chk_all("h1", 5'b00000, 4'd1, 2'd0);
    step(3'b001, 1'b0); chk_all("h2", 5'b00000, 4'd2, 2'd0);
    step(3'b001, 1'b0); chk_all("h3_vend", 5'b10001, 4'd0, 2'd0);
    step(3'b000, 1'b0); chk_all("h3_idle", 5'b00000, 4'd0, 2'd1);

    // 1.0 then 2.0: drink, coin_1, coin_0p5, idle.
    step(3'b010, 1'b0); chk_all("o1", 5'b00000, 4'd2, 2'd1);
    step(3'b100, 1'b0); chk_all("o2_vend", 5'b10001, 4'd0, 2'd1);
    step(3'b000, 1'b0); chk_all("o2_c1", 5'b01001, 4'd0, 2'd2);
    step(3'b000, 1'b0); chk_all("o2_c05", 5'b00101, 4'd0, 2'd2);
    step(3'b000, 1'b0); chk_all("o2_idle", 5'b00000, 4'd0, 2'd2);

    // 1.0 then cancel together with 0.5: reject + coin_1 refund.
    step(3'b010, 1'b0); chk_all("c1", 5'b00000, 4'd2, 2'd2);
    step(3'b001, 1'b1); chk_all("c_refund", 5'b01011, 4'd0, 2'd2);
    step(3'b000, 1'b0); chk_all("c_idle", 5'b00000, 4'd0, 2'd2);

    // 2.0 then 1.0 during VEND and during CHANGE: both rejected.
    step(3'b100, 1'b0); chk_all("b_vend", 5'b10001, 4'd0, 2'd2);
    step(3'b010, 1'b0); chk_all("b_rej_vend", 5'b00111, 4'd0, 2'd3);
    step(3'b010, 1'b0); chk_all("b_rej_chg", 5'b00010, 4'd0, 2'd3);
    step(3'b000, 1'b0); chk_all("b_idle", 5'b00000, 4'd0, 2'd3);

    // Multi-hot coin with credit 1: rejected, credit kept.
    step(3'b001, 1'b0); chk_all("m1", 5'b00000, 4'd1, 2'd3);
    step(3'b011, 1'b0); chk_all("m_rej", 5'b00010, 4'd1, 2'd3);
    step(3'b000, 1'b0); chk_all("m_after", 5'b00000, 4'd1, 2'd3);
    // Drain the 0.5 credit via cancel, then cancel at zero credit does nothing.
    step(3'b000, 1'b1); chk_all("m_refund", 5'b00101, 4'd0, 2'd3);
    step(3'b000, 1'b0); chk_all("m_idle", 5'b00000, 4'd0, 2'd3);
    step(3'b000, 1'b1); chk_all("z_cancel", 5'b00000, 4'd0, 2'd3);
    step(3'b000, 1'b0); chk_all("z_after", 5'b00000, 4'd0, 2'd3);

    // Fourth vend: sold_cnt wraps 3 -> 0.
    step(3'b010, 1'b0); chk_all("w1", 5'b00000, 4'd2, 2'd3);
    step(3'b001, 1'b0); chk_all("w_vend", 5'b10001, 4'd0, 2'd3);
    step(3'b000, 1'b0); chk_all("w_wrap", 5'b00000, 4'd0, 2'd0);

    // Reset in the middle of a two-coin change sequence.
    step(3'b010, 1'b0); chk_all("r1", 5'b00000, 4'd2, 2'd0);
    step(3'b100, 1'b0); chk_all("r_vend", 5'b10001, 4'd0, 2'd0);
    step(3'b000, 1'b0); chk_all("r_c1", 5'b01001, 4'd0, 2'd1);
    rst = 1'b1;
    step(3'b000, 1'b0); chk_all("r_reset", 5'b00000, 4'd0, 2'd0);
    rst = 1'b0;
    step(3'b000, 1'b0); chk_all("r_after", 5'b00000, 4'd0, 2'd0);
    step(3'b001, 1'b0); chk_all("r_accept", 5'b00000, 4'd1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised vending-machine controller, the successor to the fixed 1.5-unit seller. It accumulates credit from three coin denominations and dispenses one drink when credit reaches a programmable price. It returns change serially as 1.0 and 0.5 coins, supports a cancel/refund request, rejects illegal or ill-timed coins, and keeps a wrapping sales counter. It sits between the coin-acceptor front end and the dispenser/hopper drivers.

## Interface
- PRICE, 3: drink price in half-units (0.5 coin = 1 unit); legal range 1..(2^CW − 4).
- CW, 4: credit/change register width; must hold PRICE+3.
- CNT_W, 8: sales counter width.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- money  in  3  coin insert, one-hot; bit0 = 0.5 (1 unit), bit1 = 1.0 (2 units), bit2 = 2.0 (4 units); sampled each edge.
- cancel  in  1  refund request; level sampled each edge.
- drink  out  1  one-cycle dispense pulse.
- coin_1  out  1  one-cycle pulse returning a 1.0 coin.
- coin_0p5  out  1  one-cycle pulse returning a 0.5 coin.
- coin_reject  out  1  one-cycle pulse: the coin sampled on the previous edge is returned untouched.
- busy  out  1  high when not in COLLECT.
- credit  out  CW  current accumulated credit, in units.
- sold_cnt  out  CNT_W  drinks dispensed since reset, wraps modulo 2^CNT_W.

## Operation
- States: COLLECT, VEND, CHANGE. Registers: state, credit, change (CW bits), coin_reject, sold_cnt.
- Coin value v: 1/2/4 for the legal one-hot codes; money == 0 means no coin.
- COLLECT, legal coin, cancel low: if credit+v ≥ PRICE → VEND, change ← credit+v−PRICE, credit ← 0; else credit ← credit+v, stay.
- COLLECT, cancel high with credit > 0 → CHANGE, change ← credit, credit ← 0. Cancel with credit == 0 is ignored.
- Cancel and a coin on the same edge: cancel wins, the coin is rejected (coin_reject next cycle), refund equals prior credit only.
- Multi-hot money (two or more bits) in any state: rejected, credit unchanged.
- Any nonzero money while busy (VEND or CHANGE): rejected, no credit effect. Cancel is ignored while busy.
- VEND (exactly one cycle): drink = 1, sold_cnt increments on the exiting edge; next state CHANGE if change > 0, else COLLECT.
- CHANGE: each cycle emits exactly one coin, largest first: change ≥ 2 → coin_1 = 1, change −= 2; change == 1 → coin_0p5 = 1, change −= 1. Moves to COLLECT on the edge where change reaches 0.
- drink, coin_1, coin_0p5 and busy decode from registered state/change only, never from inputs; coin_1 and coin_0p5 are never high together.
- Arithmetic: credit+v is evaluated at CW+1 bits, so no overflow is possible within the legal PRICE range. Maximum change is 3 units, so at most 2 coins are returned.

## Timing
- Reset (rst high at an edge): state COLLECT, credit 0, change 0, sold_cnt 0, coin_reject 0. All outputs 0 during the following cycle. rst mid-VEND or mid-CHANGE aborts: no further drink or coin pulses, and undispensed change is lost.
- Coin sampled at edge E0 completing the price: drink is high during E0→E1.
- Change coins follow on E1→E2 and E2→E3 as needed.
- Earliest next accepted coin is at the edge that leaves VEND/CHANGE for COLLECT plus one, i.e. the first edge sampled while busy = 0.
- Latency from price-completing coin to idle: 1 cycle with no change, 2 cycles for 1 change coin, 3 cycles for 2 change coins.
- coin_reject is high for exactly the cycle after the offending sampling edge. Back-to-back rejects give back-to-back pulses.
- sold_cnt wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan
- PRICE=3: insert 0.5, 0.5, 0.5 on consecutive edges -> credit 1, 2, then drink pulse one cycle, no coin pulses, sold_cnt=1, busy low the next cycle.
- PRICE=3: insert 1.0 then 2.0 -> credit 2, then drink; then coin_1 for one cycle, then coin_0p5 for one cycle; COLLECT after 3 busy cycles.
- PRICE=3: insert 1.0, then cancel together with a 0.5 coin -> coin_reject pulse, coin_1 pulse, credit 0, no drink.
- Insert 2.0 (PRICE=3), then 1.0 during VEND and during CHANGE -> coin_reject on each, credit stays 0, single coin_0p5 change.
- money=3'b011 in COLLECT with credit 1 -> coin_reject pulse, credit stays 1; cancel with credit 0 -> no output activity.
- CNT_W=2, four vends -> sold_cnt 1, 2, 3, 0. Assert rst during CHANGE -> all outputs 0 on the next cycle, credit 0, state COLLECT.
